// File: rtl/mdu_sequencer.sv
// mdu_sequencer: fixed-latency multiply/divide controller owning the HI/LO registers.
module mdu_sequencer #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  operation,
    input  logic        start,
    input  logic        cancel,
    input  logic        readSel,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataRead
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [63:0] pend, pend_n;
    logic [31:0] hi, lo, hi_n, lo_n;
    logic        done_n;

    logic [63:0] smul, umul;
    logic        sgn, dz;
    logic [31:0] n_mag, d_mag, d_safe, q_mag, r_mag, quot, rem;

    assign smul = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    assign umul = {32'd0, operand1} * {32'd0, operand2};

    // One unsigned divider serves both flavours; signed results are rebuilt from magnitudes.
    assign sgn    = operation == OP_DIV;
    assign dz     = operand2 == 32'd0;
    assign n_mag  = (sgn && operand1[31]) ? -operand1 : operand1;
    assign d_mag  = (sgn && operand2[31]) ? -operand2 : operand2;
    assign d_safe = dz ? 32'd1 : d_mag;
    assign q_mag  = n_mag / d_safe;
    assign r_mag  = n_mag % d_safe;
    assign quot   = dz ? 32'hFFFF_FFFF : (sgn && (operand1[31] ^ operand2[31])) ? -q_mag : q_mag;
    assign rem    = dz ? operand1 : (sgn && operand1[31]) ? -r_mag : r_mag;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        hi_n    = hi;
        lo_n    = lo;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start && !cancel) begin
                if (operation == OP_MULT || operation == OP_MULTU) begin
                    pend_n  = operation == OP_MULT ? smul : umul;
                    cnt_n   = 5'(MUL_LAT - 1);
                    state_n = MUL;
                end else if (operation == OP_DIV || operation == OP_DIVU) begin
                    pend_n  = {rem, quot};
                    cnt_n   = 5'(DIV_LAT - 1);
                    state_n = DIV;
                end else begin
                    hi_n = operation == OP_MTHI ? operand1 : hi;
                    lo_n = operation == OP_MTLO ? operand1 : lo;
                end
            end
        end else if (cancel) begin
            state_n = IDLE;
        end else if (cnt == 5'd0) begin
            {hi_n, lo_n} = pend;
            done_n       = 1'b1;
            state_n      = IDLE;
        end else begin
            cnt_n = cnt - 5'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            pend  <= 64'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            hi    <= hi_n;
            lo    <= lo_n;
            done  <= done_n;
        end
    end

    assign busy     = state != IDLE;
    assign dataRead = readSel ? hi : lo;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed plus randomized checks of mdu_sequencer against an arithmetic model.
module tb_mdu_sequencer;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5, OP_MTLO = 3'd6;

    logic        clock = 1'b0, reset = 1'b0, start = 1'b0, cancel = 1'b0, readSel = 1'b0;
    logic [31:0] operand1 = '0, operand2 = '0;
    logic [2:0]  operation = '0;
    logic        busy, done;
    logic [31:0] dataRead;

    int          cmp = 0, err = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mdu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset(reset), .operand1(operand1), .operand2(operand2),
        .operation(operation), .start(start), .cancel(cancel), .readSel(readSel),
        .busy(busy), .done(done), .dataRead(dataRead)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        longint unsigned p;
        logic [63:0] v;
        case (op)
            OP_MULT: begin
                x = longint'(int'(a));
                y = longint'(int'(b));
                v = 64'(x * y);
            end
            OP_MULTU: begin
                p = longint'(a) * longint'(b);
                v = p;
            end
            OP_DIV: begin
                if (b == 0) v = {a, 32'hFFFF_FFFF};
                else begin
                    x = longint'(int'(a));
                    y = longint'(int'(b));
                    q = x / y;
                    r = x % y;
                    v = {r[31:0], q[31:0]};
                end
            end
            default: v = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag);
        readSel = 1'b1;
        #1 check({tag, ".hi"}, dataRead, m_hi);
        readSel = 1'b0;
        #1 check({tag, ".lo"}, dataRead, m_lo);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        int  n = 0;
        bit  early = 0;
        operation = op;
        operand1  = a;
        operand2  = b;
        start     = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        while (busy && n < 64) begin
            n++;
            early |= done;
            if (n == 1) begin
                readSel = 1'b0;
                #1 check({tag, ".stale"}, dataRead, m_lo);
            end
            if (inject && n == 2) begin
                start     = 1'b1;
                operation = OP_DIV;
                operand1  = 32'd1000;
                operand2  = 32'd3;
            end else start = 1'b0;
            @(negedge clock);
        end
        start = 1'b0;
        check({tag, ".lat"}, n, (op == OP_MULT || op == OP_MULTU) ? MUL_LAT : DIV_LAT);
        check({tag, ".early_done"}, 32'(early), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd1);
        {m_hi, m_lo} = ref_model(op, a, b);
        check_hilo(tag);
        @(negedge clock);
        check({tag, ".done_fall"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit saw_done;
        logic [2:0]  op;
        logic [31:0] a, b;
        repeat (2) @(negedge clock);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_hilo("rst");
        reset = 1'b1;
        @(negedge clock);

        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 0);
        run_op("divu0", OP_DIVU, 32'h1234, 32'd0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div0", OP_DIV, 32'hFFFF_FF00, 32'd0, 0);

        operation = OP_MTHI;
        operand1  = 32'hDEAD_BEEF;
        start     = 1'b1;
        @(negedge clock);
        check("mthi.busy", 32'(busy), 32'd0);
        operation = OP_MTLO;
        operand1  = 32'hCAFE_F00D;
        @(negedge clock);
        start = 1'b0;
        check("mtlo.busy", 32'(busy), 32'd0);
        m_hi = 32'hDEAD_BEEF;
        m_lo = 32'hCAFE_F00D;
        check_hilo("mt");

        operation = OP_MTHI;
        operand1  = 32'h1111_2222;
        start     = 1'b1;
        cancel    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        cancel = 1'b0;
        check("mt_cancel.busy", 32'(busy), 32'd0);
        check_hilo("mt_cancel");

        operation = OP_MULT;
        operand1  = 32'd7;
        operand2  = 32'd9;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        check("cancel.busy", 32'(busy), 32'd0);
        check("cancel.done", 32'(done), 32'd0);
        check_hilo("cancel");
        @(negedge clock);
        check("cancel.done2", 32'(done), 32'd0);

        run_op("inject", OP_MULT, 32'h0001_0000, 32'h0003_0000, 1);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
            if (i % 6 == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op($sformatf("rnd%0d", i), op, a, b, bit'($urandom_range(0, 1)));
        end

        operation = OP_DIV;
        operand1  = 32'd50;
        operand2  = 32'd5;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1 check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        m_hi = '0;
        m_lo = '0;
        check_hilo("arst");
        @(negedge clock);
        #2 reset = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(negedge clock);
            saw_done |= done | busy;
        end
        check("arst.quiet", 32'(saw_done), 32'd0);
        check_hilo("arst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Controller for the multiply/divide resource in the EX stage. It accepts one MDU operation at a time and runs a fixed-latency multiply or divide sequence. It owns the HI/LO architectural registers, raises busy so EX can stall dependent instructions, and supports a flush (cancel) from the exception/branch logic. Results commit to HI/LO only on completion.

Parameters:
MUL_LAT, 5, cycles busy is high for MULT/MULTU (legal range 1..31)
DIV_LAT, 10, cycles busy is high for DIV/DIVU (legal range 1..31)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
operand1  input  32  rs value (dividend / multiplicand / MTHI-MTLO source)
operand2  input  32  rt value (divisor / multiplier)
operation  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
start  input  1  issue strobe, sampled on the rising edge; EX already gates it with its own stall
cancel  input  1  abort the in-flight operation
readSel  input  1  0 selects LO, 1 selects HI
busy  output  1  operation in flight; EX must stall any MDU user while high
done  output  1  one-cycle pulse, the cycle after HI/LO commit
dataRead  output  32  committed HI or LO per readSel (combinational)

Behaviour:
- Single clock domain. reset low clears immediately, asynchronously: HI=0, LO=0, state IDLE, counter=0, pending result=0, busy=0, done=0.
- States:
  - IDLE: no operation in flight.
  - MUL: multiply in flight.
  - DIV: divide in flight.
- busy is registered: it is 1 exactly when the state is MUL or DIV.
- IDLE, start=1, cancel=0:
  - MULT/MULTU: at the edge, capture the 64-bit product into the pending register (signed or unsigned), load counter=MUL_LAT-1, go to MUL.
  - DIV/DIVU: capture quotient into pending-LO and remainder into pending-HI, load counter=DIV_LAT-1, go to DIV.
  - MTHI/MTLO: write operand1 to HI or LO at that edge. No busy, stay in IDLE.
  - NONE/reserved: no effect.
- MUL/DIV, per cycle:
  - Counter non-zero: decrement.
  - Counter zero: at that edge commit pending HI/LO, go to IDLE, busy falls. done=1 for the following cycle.
  - Result: busy is high for exactly MUL_LAT (or DIV_LAT) cycles. The committed value is visible on dataRead the cycle busy is first low.
- Arithmetic:
  - Signed divide truncates toward zero. The remainder takes the sign of the dividend.
  - Divide by zero (signed or unsigned): LO=32'hFFFFFFFF, HI=operand1. Full DIV_LAT latency still applies.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored. No change to state, counter or pending result.
- cancel while busy:
  - Return to IDLE at the edge; busy=0 the next cycle.
  - HI/LO unchanged, no done pulse.
  - cancel has priority over a commit on the same edge.
- cancel and start in the same IDLE cycle: start is ignored, including MTHI/MTLO.
- dataRead always reflects committed HI/LO. While busy it shows the old values.
- Asynchronous reset mid-operation: the operation is abandoned and HI/LO return to 0.

Test Plan:
- Reset, then MULT operand1=0xFFFFFFFE, operand2=3 -> busy high 5 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA. Then MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV operand1=0xFFFFFFF9 (-7), operand2=2 -> busy high 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU operand1=0x1234, operand2=0 -> after 10 cycles LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xDEADBEEF, then MTLO 0xCAFEF00D on consecutive cycles -> busy never asserts, readSel=1 gives 0xDEADBEEF, readSel=0 gives 0xCAFEF00D on the next cycle.
- Start MULT, assert cancel on the 3rd busy cycle -> busy low the next cycle, no done, HI/LO hold their prior values. Pulse start with DIV during a MULT busy window -> ignored, MULT result commits on schedule.
- Drive reset low asynchronously mid-DIV -> busy=0, HI=LO=0 immediately, no done after release.
